// File: rtl/interval_timer_pkg.sv
// rtl/interval_timer_pkg.sv - register map, CTRL bit positions and FSM states shared by the interval timer
package interval_timer_pkg;

  localparam logic [2:0] TIMER_CTRL     = 3'd0;
  localparam logic [2:0] TIMER_PRESCALE = 3'd1;
  localparam logic [2:0] TIMER_RELOAD   = 3'd2;
  localparam logic [2:0] TIMER_STATUS   = 3'd3;
  localparam logic [2:0] TIMER_COUNT    = 3'd4;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/interval_timer_counter.sv
// rtl/interval_timer_counter.sv - generic up/down counter with synchronous load back to its low value
module interval_timer_counter #(
  parameter int unsigned Width = 16,
  parameter int unsigned Low   = 0,
  parameter bit          Up    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  output logic [Width-1:0] value
);

  logic [Width-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = Width'(Low);
    end else if (en) begin
      value_d = Up ? value_q + Width'(1) : value_q - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= Width'(Low);
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - programmable down-counting interval timer with prescaler and sticky interrupt
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int unsigned Width         = 32,
  parameter int unsigned PrescaleWidth = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        irq
);

  timer_state_t             state_d, state_q;
  logic [2:0]               ctrl_d, ctrl_q;
  logic [PrescaleWidth-1:0] prescale_d, prescale_q;
  logic [PrescaleWidth-1:0] pre_lat_d, pre_lat_q;
  logic [Width-1:0]         reload_d, reload_q;
  logic [Width-1:0]         count_d, count_q;
  logic                     pending_d, pending_q;
  logic                     irq_d, irq_q;
  logic                     rsp_valid_d, rsp_valid_q;
  logic [31:0]              rsp_rdata_d, rsp_rdata_q;

  logic                     wr, rd, disable_wr, start, tick, expire;
  logic                     pre_en, pre_load;
  logic [PrescaleWidth-1:0] pre_value;

  interval_timer_counter #(
    .Width (PrescaleWidth),
    .Low   (0),
    .Up    (1'b1)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (pre_en),
    .load  (pre_load),
    .value (pre_value)
  );

  always_comb begin
    wr         = req_valid && req_we;
    rd         = req_valid && !req_we;
    // A disabling write overrides any tick landing in the same cycle.
    disable_wr = wr && (req_addr == TIMER_CTRL) && !req_wdata[CTRL_ENABLE];
    start      = (state_q == IDLE) && ctrl_q[CTRL_ENABLE] && !disable_wr;
    tick       = (state_q == RUN) && (pre_value == pre_lat_q) && !disable_wr;
    expire     = tick && (count_q == '0);
    pre_en     = (state_q == RUN) && !disable_wr;
    pre_load   = start || tick;
    pre_lat_d  = pre_load ? prescale_q : pre_lat_q;

    state_d = state_q;
    if (disable_wr) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
    end else if (expire && !ctrl_q[CTRL_PERIODIC]) begin
      state_d = DONE;
    end

    count_d = count_q;
    if (start || (expire && ctrl_q[CTRL_PERIODIC])) begin
      count_d = reload_q;
    end else if (tick && !expire) begin
      count_d = count_q - Width'(1);
    end

    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    reload_d   = reload_q;
    pending_d  = pending_q;
    if (wr) begin
      case (req_addr)
        TIMER_CTRL:     ctrl_d     = req_wdata[2:0];
        TIMER_PRESCALE: prescale_d = req_wdata[PrescaleWidth-1:0];
        TIMER_RELOAD:   reload_d   = req_wdata[Width-1:0];
        TIMER_STATUS:   if (req_wdata[0]) pending_d = 1'b0;
        default:        ;
      endcase
    end
    if (expire) begin
      pending_d = 1'b1;
    end
    irq_d = pending_d && ctrl_d[CTRL_IRQ_EN];

    rsp_valid_d = rd;
    rsp_rdata_d = '0;
    if (rd) begin
      case (req_addr)
        TIMER_CTRL:     rsp_rdata_d = 32'(ctrl_q);
        TIMER_PRESCALE: rsp_rdata_d = 32'(prescale_q);
        TIMER_RELOAD:   rsp_rdata_d = 32'(reload_q);
        TIMER_STATUS:   rsp_rdata_d = 32'(pending_q);
        TIMER_COUNT:    rsp_rdata_d = 32'(count_q);
        default:        rsp_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      prescale_q  <= '0;
      pre_lat_q   <= '0;
      reload_q    <= '0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      pre_lat_q   <= pre_lat_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      irq_q       <= irq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = 1'b1;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign irq       = irq_q;

endmodule
